// File: rtl/memoria_instrucao_carregavel.sv
// memoria_instrucao_carregavel
//   Instruction memory that is filled at runtime from a loader stream and then
//   read by the processor with a one-cycle registered read.
//
//   Optional build macro: INSTR_PARIDADE_EN
//     When defined, every stored word keeps an even-parity bit. The extra
//     output erro_paridade flags a parity mismatch on an in-range fetch.
//
//   Ports
//     clock, reset           : single clock, synchronous active-high reset
//     endereco, le_en        : fetch word address and fetch request
//     instrucao              : registered fetched word (0 = NOP)
//     instrucao_valida       : instrucao holds the result of a fetch made in EXECUCAO
//     fora_faixa             : last fetch address >= palavras_carregadas
//     carga_inicio           : start or restart a program load
//     carga_dado/valido      : loader word and its valid flag
//     carga_pronto           : loader may present a word (high only in CARGA)
//     carga_fim              : last-word marker / terminate load
//     carregando             : high while in CARGA
//     palavras_carregadas    : number of words in the current program
//     estado_dbg             : current FSM state (VAZIA=0, CARGA=1, EXECUCAO=2)
//     erro_paridade          : (INSTR_PARIDADE_EN only) parity error on last fetch
//
//   Loader handshake: a word is transferred on a rising edge where
//   carga_valido && carga_pronto are both high and carga_inicio is low.
//   carga_pronto does not depend on carga_valido.
module memoria_instrucao_carregavel #(
  parameter int LARGURA      = 32,
  parameter int PROFUNDIDADE = 128,
  parameter int LARGURA_END  = 7
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [31:0]            endereco,
  input  logic                   le_en,
  output logic [LARGURA-1:0]     instrucao,
  output logic                   instrucao_valida,
  output logic                   fora_faixa,
  input  logic                   carga_inicio,
  input  logic [LARGURA-1:0]     carga_dado,
  input  logic                   carga_valido,
  output logic                   carga_pronto,
  input  logic                   carga_fim,
  output logic                   carregando,
  output logic [LARGURA_END:0]   palavras_carregadas,
  output logic [1:0]             estado_dbg
`ifdef INSTR_PARIDADE_EN
  ,
  output logic                   erro_paridade
`endif
);

  localparam logic [1:0] VAZIA    = 2'd0;
  localparam logic [1:0] CARGA    = 2'd1;
  localparam logic [1:0] EXECUCAO = 2'd2;

  localparam logic [LARGURA_END-1:0] ULTIMO = LARGURA_END'(PROFUNDIDADE - 1);

`ifdef INSTR_PARIDADE_EN
  localparam int LARG_MEM = LARGURA + 1;
`else
  localparam int LARG_MEM = LARGURA;
`endif

  logic [LARG_MEM-1:0]    mem_q [PROFUNDIDADE];

  logic [1:0]             estado_q, estado_d;
  logic [LARGURA_END-1:0] ptr_q, ptr_d;
  logic [LARGURA_END:0]   palavras_q, palavras_d;
  logic [LARGURA-1:0]     instr_q, instr_d;
  logic                   valida_q, valida_d;
  logic                   fora_q, fora_d;
  logic                   escreve;
  logic                   em_faixa;
  logic [LARG_MEM-1:0]    palavra_lida;
`ifdef INSTR_PARIDADE_EN
  logic                   erro_q, erro_d;
`endif

  // Full 32-bit compare so a huge PC never aliases onto a low index.
  assign em_faixa     = endereco < 32'(palavras_q);
  assign palavra_lida = mem_q[endereco[LARGURA_END-1:0]];

  always_comb begin
    estado_d   = estado_q;
    ptr_d      = ptr_q;
    palavras_d = palavras_q;
    instr_d    = instr_q;
    valida_d   = valida_q;
    fora_d     = fora_q;
    escreve    = 1'b0;
`ifdef INSTR_PARIDADE_EN
    erro_d     = erro_q;
`endif
    case (estado_q)
      VAZIA: begin
        instr_d  = '0;
        valida_d = 1'b0;
        fora_d   = 1'b0;
`ifdef INSTR_PARIDADE_EN
        erro_d   = 1'b0;
`endif
        if (carga_inicio) begin
          estado_d   = CARGA;
          ptr_d      = '0;
          palavras_d = '0;
        end
      end
      CARGA: begin
        instr_d  = '0;
        valida_d = 1'b0;
        fora_d   = 1'b0;
`ifdef INSTR_PARIDADE_EN
        erro_d   = 1'b0;
`endif
        // Restart wins over any word presented in the same cycle.
        if (carga_inicio) begin
          ptr_d      = '0;
          palavras_d = '0;
        end else if (carga_valido) begin
          escreve    = 1'b1;
          ptr_d      = ptr_q + 1'b1;
          palavras_d = {1'b0, ptr_q} + 1'b1;
          if (carga_fim || ptr_q == ULTIMO) estado_d = EXECUCAO;
        end else if (carga_fim) begin
          estado_d = EXECUCAO;
        end
      end
      EXECUCAO: begin
        if (carga_inicio) begin
          estado_d   = CARGA;
          ptr_d      = '0;
          palavras_d = '0;
          instr_d    = '0;
          valida_d   = 1'b0;
          fora_d     = 1'b0;
`ifdef INSTR_PARIDADE_EN
          erro_d     = 1'b0;
`endif
        end else if (le_en) begin
          valida_d = 1'b1;
          if (em_faixa) begin
            instr_d = palavra_lida[LARGURA-1:0];
            fora_d  = 1'b0;
`ifdef INSTR_PARIDADE_EN
            // Stored bit makes the whole entry even; odd XOR means corruption.
            erro_d  = ^palavra_lida;
`endif
          end else begin
            instr_d = '0;
            fora_d  = 1'b1;
`ifdef INSTR_PARIDADE_EN
            erro_d  = 1'b0;
`endif
          end
        end
      end
      default: estado_d = VAZIA;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      estado_q   <= VAZIA;
      ptr_q      <= '0;
      palavras_q <= '0;
      instr_q    <= '0;
      valida_q   <= 1'b0;
      fora_q     <= 1'b0;
`ifdef INSTR_PARIDADE_EN
      erro_q     <= 1'b0;
`endif
    end else begin
      estado_q   <= estado_d;
      ptr_q      <= ptr_d;
      palavras_q <= palavras_d;
      instr_q    <= instr_d;
      valida_q   <= valida_d;
      fora_q     <= fora_d;
`ifdef INSTR_PARIDADE_EN
      erro_q     <= erro_d;
`endif
    end
  end

  // Storage is never cleared; palavras_q bounds what is reachable.
  always_ff @(posedge clock) begin
    if (escreve && !reset) begin
`ifdef INSTR_PARIDADE_EN
      mem_q[ptr_q] <= {^carga_dado, carga_dado};
`else
      mem_q[ptr_q] <= carga_dado;
`endif
    end
  end

  assign instrucao           = instr_q;
  assign instrucao_valida    = valida_q;
  assign fora_faixa          = fora_q;
  assign carga_pronto        = (estado_q == CARGA);
  assign carregando          = (estado_q == CARGA);
  assign palavras_carregadas = palavras_q;
  assign estado_dbg          = estado_q;
`ifdef INSTR_PARIDADE_EN
  assign erro_paridade       = erro_q;
`endif

endmodule

// File: tb/tb_memoria_instrucao_carregavel.sv
module tb_memoria_instrucao_carregavel;

  localparam int LARGURA      = 32;
  localparam int PROFUNDIDADE = 128;
  localparam int LARGURA_END  = 7;
  localparam int W            = LARGURA + 2;

  logic                 clock = 1'b0;
  logic                 reset = 1'b1;
  logic [31:0]          endereco = '0;
  logic                 le_en = 1'b0;
  logic [LARGURA-1:0]   instrucao;
  logic                 instrucao_valida;
  logic                 fora_faixa;
  logic                 carga_inicio = 1'b0;
  logic [LARGURA-1:0]   carga_dado = '0;
  logic                 carga_valido = 1'b0;
  logic                 carga_pronto;
  logic                 carga_fim = 1'b0;
  logic                 carregando;
  logic [LARGURA_END:0] palavras_carregadas;
  logic [1:0]           estado_dbg;
`ifdef INSTR_PARIDADE_EN
  logic                 erro_paridade;
`endif

  int checks = 0;
  int errors = 0;

  // {instrucao, instrucao_valida, fora_faixa}
  logic [W-1:0] exp_q[$];
  logic         fetch_seen = 1'b0;

  memoria_instrucao_carregavel #(
    .LARGURA(LARGURA), .PROFUNDIDADE(PROFUNDIDADE), .LARGURA_END(LARGURA_END)
  ) dut (
    .clock(clock), .reset(reset), .endereco(endereco), .le_en(le_en),
    .instrucao(instrucao), .instrucao_valida(instrucao_valida),
    .fora_faixa(fora_faixa), .carga_inicio(carga_inicio),
    .carga_dado(carga_dado), .carga_valido(carga_valido),
    .carga_pronto(carga_pronto), .carga_fim(carga_fim),
    .carregando(carregando), .palavras_carregadas(palavras_carregadas),
    .estado_dbg(estado_dbg)
`ifdef INSTR_PARIDADE_EN
    , .erro_paridade(erro_paridade)
`endif
  );

  // ---------------- clock / watchdog ----------------
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "watchdog");
  end

  // ---------------- helpers ----------------
  task automatic chk(input string nome, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nome, got, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clock);
  endtask

  task automatic start_load();
    carga_inicio = 1'b1;
    cyc();
    carga_inicio = 1'b0;
  endtask

  task automatic send(input logic [LARGURA-1:0] d, input logic fim);
    carga_valido = 1'b1;
    carga_dado   = d;
    carga_fim    = fim;
    cyc();
    carga_valido = 1'b0;
    carga_fim    = 1'b0;
  endtask

  task automatic fetch(input logic [31:0] addr, input logic [LARGURA-1:0] e_instr,
                       input logic e_val, input logic e_fora);
    endereco = addr;
    le_en    = 1'b1;
    exp_q.push_back({e_instr, e_val, e_fora});
    cyc();
    le_en    = 1'b0;
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(posedge clock) fetch_seen <= le_en;

  always @(negedge clock) begin
    logic [W-1:0] e;
    if (fetch_seen) begin
      if (exp_q.size() == 0) begin
        chk("fetch_unexpected", 64'd1, 64'd0);
      end else begin
        e = exp_q.pop_front();
        chk("fetch_instrucao", 64'(instrucao), 64'(e[W-1:2]));
        chk("fetch_valida", 64'(instrucao_valida), 64'(e[1]));
        chk("fetch_fora_faixa", 64'(fora_faixa), 64'(e[0]));
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    repeat (3) @(posedge clock);
    cyc();
    reset = 1'b0;

    // reset values
    chk("rst_instrucao", 64'(instrucao), 64'd0);
    chk("rst_valida", 64'(instrucao_valida), 64'd0);
    chk("rst_fora", 64'(fora_faixa), 64'd0);
    chk("rst_pronto", 64'(carga_pronto), 64'd0);
    chk("rst_carregando", 64'(carregando), 64'd0);
    chk("rst_palavras", 64'(palavras_carregadas), 64'd0);
    chk("rst_estado", 64'(estado_dbg), 64'd0);

    // fetch while empty
    fetch(32'd0, 32'd0, 1'b0, 1'b0);

    // 3-word load ending with carga_fim on the last word
    start_load();
    chk("load_carregando", 64'(carregando), 64'd1);
    chk("load_pronto", 64'(carga_pronto), 64'd1);
    send(32'h6401_0001, 1'b0);
    send(32'h6402_0001, 1'b0);
    send(32'hF800_0000, 1'b1);
    chk("load3_palavras", 64'(palavras_carregadas), 64'd3);
    chk("load3_carregando", 64'(carregando), 64'd0);
    chk("load3_pronto", 64'(carga_pronto), 64'd0);
    fetch(32'd1, 32'h6402_0001, 1'b1, 1'b0);
    fetch(32'd0, 32'h6401_0001, 1'b1, 1'b0);
    fetch(32'd2, 32'hF800_0000, 1'b1, 1'b0);
    fetch(32'd3, 32'd0, 1'b1, 1'b1);
    fetch(32'h0001_0000, 32'd0, 1'b1, 1'b1);
    fetch(32'd2, 32'hF800_0000, 1'b1, 1'b0);
    // le_en low: outputs hold
    endereco = 32'd0;
    cyc();
    chk("hold_instrucao", 64'(instrucao), 64'hF800_0000);
    chk("hold_valida", 64'(instrucao_valida), 64'd1);
    chk("hold_fora", 64'(fora_faixa), 64'd0);

    // full-depth stream with no carga_fim -> automatic EXECUCAO
    start_load();
    chk("reload_valida", 64'(instrucao_valida), 64'd0);
    chk("reload_palavras", 64'(palavras_carregadas), 64'd0);
    for (int i = 0; i < PROFUNDIDADE; i++) send(32'h1000_0000 + 32'(i), 1'b0);
    chk("full_palavras", 64'(palavras_carregadas), 64'd128);
    chk("full_carregando", 64'(carregando), 64'd0);
    chk("full_pronto", 64'(carga_pronto), 64'd0);
    send(32'h0000_0BAD, 1'b0);
    chk("full_extra_ignored", 64'(palavras_carregadas), 64'd128);
    fetch(32'd127, 32'h1000_007F, 1'b1, 1'b0);
    fetch(32'd0, 32'h1000_0000, 1'b1, 1'b0);
    fetch(32'd64, 32'h1000_0040, 1'b1, 1'b0);
    fetch(32'd128, 32'd0, 1'b1, 1'b1);

    // restart in the middle of a load, same-cycle data dropped
    start_load();
    send(32'h0000_00AA, 1'b0);
    send(32'h0000_00BB, 1'b0);
    chk("mid_palavras2", 64'(palavras_carregadas), 64'd2);
    carga_inicio = 1'b1;
    carga_valido = 1'b1;
    carga_dado   = 32'h0000_DEAD;
    cyc();
    carga_inicio = 1'b0;
    carga_valido = 1'b0;
    chk("restart_palavras", 64'(palavras_carregadas), 64'd0);
    chk("restart_carregando", 64'(carregando), 64'd1);
    send(32'h0000_0001, 1'b1);
    chk("restart_load1", 64'(palavras_carregadas), 64'd1);
    fetch(32'd0, 32'h0000_0001, 1'b1, 1'b0);
    fetch(32'd1, 32'd0, 1'b1, 1'b1);

    // carga_fim without a word
    start_load();
    send(32'h0000_0055, 1'b0);
    carga_fim = 1'b1;
    cyc();
    carga_fim = 1'b0;
    chk("fim_only_palavras", 64'(palavras_carregadas), 64'd1);
    chk("fim_only_carregando", 64'(carregando), 64'd0);
    fetch(32'd0, 32'h0000_0055, 1'b1, 1'b0);

    // reset in the middle of a load
    start_load();
    for (int i = 0; i < 5; i++) send(32'h2000_0000 + 32'(i), 1'b0);
    chk("pre_reset_palavras", 64'(palavras_carregadas), 64'd5);
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    chk("midrst_palavras", 64'(palavras_carregadas), 64'd0);
    chk("midrst_carregando", 64'(carregando), 64'd0);
    chk("midrst_estado", 64'(estado_dbg), 64'd0);
    fetch(32'd0, 32'd0, 1'b0, 1'b0);

`ifdef INSTR_PARIDADE_EN
    start_load();
    send(32'h1234_5678, 1'b0);
    send(32'h0000_0003, 1'b1);
    fetch(32'd1, 32'h0000_0003, 1'b1, 1'b0);
    chk("par_ok", 64'(erro_paridade), 64'd0);
    dut.mem_q[0] = dut.mem_q[0] ^ 33'd1;
    fetch(32'd0, 32'h1234_5679, 1'b1, 1'b0);
    chk("par_err", 64'(erro_paridade), 64'd1);
    fetch(32'd5, 32'd0, 1'b1, 1'b1);
    chk("par_oor", 64'(erro_paridade), 64'd0);
`endif

    cyc();
    chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/memoria_instrucao_carregavel.md
Name: memoria_instrucao_carregavel

Overview:
- Parametrised instruction memory with a runtime program-load port, replacing hard-coded per-program initialisation.
- A host/loader streams instruction words through a valid/ready handshake. The processor then fetches with 1-cycle registered-read latency.
- Unloaded or out-of-range addresses return NOP (all zeros), so a stray PC executes NOPs instead of garbage.

Parameters:
- LARGURA, 32, instruction word width in bits.
- PROFUNDIDADE, 128, number of words stored.
- LARGURA_END, 7, index width; must satisfy 2^LARGURA_END >= PROFUNDIDADE.

Ports:
- clock  in  1  single clock; all state changes on rising edge.
- reset  in  1  synchronous, active-high.
- endereco  in  32  fetch word address from PC.
- le_en  in  1  fetch request; a read is captured when high.
- instrucao  out  LARGURA  registered fetched word.
- instrucao_valida  out  1  instrucao holds the result of a fetch issued in EXECUCAO.
- fora_faixa  out  1  last fetch address >= palavras_carregadas.
- carga_inicio  in  1  start/restart program load.
- carga_dado  in  LARGURA  word to write.
- carga_valido  in  1  carga_dado valid.
- carga_pronto  out  1  loader may accept a word.
- carga_fim  in  1  last word marker/terminate load.
- carregando  out  1  high in state CARGA.
- palavras_carregadas  out  LARGURA_END+1  words in the current program.

Behaviour:
- Reset values:
  - state VAZIA; ptr=0; palavras_carregadas=0.
  - instrucao=0, instrucao_valida=0, fora_faixa=0, carga_pronto=0, carregando=0.
  - Array contents are not cleared; they are unreachable because palavras_carregadas=0.
- State VAZIA:
  - Fetches return instrucao=0, valida=0, fora_faixa=0.
  - carga_inicio -> CARGA, ptr=0.
- State CARGA:
  - carga_pronto=1, carregando=1.
  - Write accepted when carga_valido && carga_pronto: mem[ptr] <= carga_dado, ptr++, palavras_carregadas <= ptr+1.
  - carga_fim with an accepted word: word is written, then -> EXECUCAO.
  - carga_fim without a word: -> EXECUCAO, count unchanged.
  - Accepted write at ptr = PROFUNDIDADE-1: auto -> EXECUCAO; carga_pronto drops the next cycle.
  - carga_inicio in CARGA has priority: ptr=0, palavras_carregadas=0, same-cycle data dropped, stays in CARGA.
  - Fetches during CARGA: instrucao=0, valida=0.
- State EXECUCAO:
  - carga_pronto=0.
  - le_en high at edge N: at edge N+1 instrucao = mem[endereco] if endereco < palavras_carregadas, else 0 with fora_faixa=1.
  - instrucao_valida=1 for every such fetch.
  - le_en low: instrucao, fora_faixa and valida hold.
  - carga_inicio -> CARGA, palavras_carregadas=0, instrucao_valida=0 next cycle.
- Address compare uses the full 32-bit endereco; upper bits are not truncated.
- palavras_carregadas=0 with le_en: result is 0 with fora_faixa=1.
- Reset mid-load: abandons the load and returns to VAZIA with count 0.
- Memory is single-port in effect: write occurs only in CARGA and read only in EXECUCAO, so there is no read/write collision.

Optional Feature:
- INSTR_PARIDADE_EN, when defined:
  - Each stored word carries an even-parity bit computed on write.
  - Adds output erro_paridade (1 bit, reset 0), registered alongside instrucao: set when a fetched in-range word's parity mismatches, cleared on the next fetch.
  - Out-of-range fetches report 0.
- Undefined: no parity storage, no erro_paridade port.

Test Plan:
- Reset, then le_en with endereco=0 -> instrucao=0, instrucao_valida=0, fora_faixa=0.
- Load 3 words (0x64010001, 0x64020001, 0xF8000000) with carga_fim on the 3rd -> palavras_carregadas=3, carregando falls. Fetch addr 1 -> 0x64020001 one cycle after le_en, valida=1.
- Fetch endereco=3, and separately endereco=0x00010000, after the 3-word load -> instrucao=0, fora_faixa=1, valida=1.
- Stream PROFUNDIDADE words with no carga_fim -> auto EXECUCAO after the 128th, count=128. Extra carga_valido is ignored (carga_pronto=0).
- Reload mid-load: 2 words accepted, then carga_inicio with carga_valido and data 0xDEAD -> count 0, data dropped. Load 1 word 0x00000001 -> fetch addr 0 returns 1, addr 1 returns 0 with fora_faixa.
- Assert reset during CARGA after 5 words -> VAZIA, count 0, fetches return 0 invalid. With INSTR_PARIDADE_EN, force a flipped stored bit -> erro_paridade=1 on that fetch.
